// File: rtl/jogador_automatico_pkg.sv
// Shared types for the memory-game auto player.
// State codes, result codes and small helpers.
package jogador_automatico_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PULSO_JOGAR    = 4'd1,
    ESPERA_LED     = 4'd2,
    GRAVA          = 4'd3,
    ESPERA_APAGAR  = 4'd4,
    REPRODUZ_PRESS = 4'd5,
    REPRODUZ_SOLTA = 4'd6,
    FIM            = 4'd8
  } estado_t;

  localparam logic [1:0] RES_NADA     = 2'b00;
  localparam logic [1:0] RES_GANHOU   = 2'b01;
  localparam logic [1:0] RES_PERDEU   = 2'b10;
  localparam logic [1:0] RES_SEM_FLAG = 2'b11;

  function automatic int max4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic one_hot4(logic [3:0] v);
    return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
  endfunction

  function automatic logic [3:0] rotl4(logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/jogador_automatico_if.sv
// Player <-> game bus: leds/status from the game,
// jogar/botoes back to it.
interface jogador_automatico_if;
  logic [3:0] leds;
  logic       pronto;
  logic       ganhou;
  logic       perdeu;
  logic       jogar;
  logic [3:0] botoes;

  modport master (
    input  leds, pronto, ganhou, perdeu,
    output jogar, botoes
  );

  modport slave (
    output leds, pronto, ganhou, perdeu,
    input  jogar, botoes
  );
endinterface

// File: rtl/memoria_jogador.sv
// Recorded-sequence RAM: synchronous write,
// asynchronous read.
module memoria_jogador #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [3:0]    rdata
);

  logic [3:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: records each exhibition, replays it.
// Optional JOGADOR_ERRO_EN adds erro_rodada (forced miss).
module jogador_automatico
  import jogador_automatico_pkg::*;
#(
  parameter int HOLD         = 5,
  parameter int GAP          = 5,
  parameter int IDLE_TIMEOUT = 20,
  parameter int JOGAR_CICLOS = 5,
  parameter int DEPTH        = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
`ifdef JOGADOR_ERRO_EN
  input  logic [3:0]  erro_rodada,
`endif
  jogador_automatico_if.master jogo,
  output logic        ocupado,
  output logic [1:0]  resultado,
  output logic        estouro,
  output logic [3:0]  db_estado
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW =
    $clog2(max4(HOLD, GAP, IDLE_TIMEOUT, JOGAR_CICLOS)) + 1;

  estado_t       estado, estado_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] wr_ptr, wr_n;
  logic [PW-1:0] rd_ptr, rd_n;
  logic [3:0]    led_q, led_n;
  logic [1:0]    res_q, res_n;
  logic          est_q, est_n;
  logic          we;
  logic          jogar_q, jogar_n;
  logic [3:0]    botoes_q, botoes_n;
  logic          ocup_q, ocup_n;
  logic [3:0]    mem_rd, press_val;

  memoria_jogador #(.DEPTH(DEPTH)) u_mem (
    .clock (clock),
    .we    (we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (led_q),
    .raddr (rd_n[AW-1:0]),
    .rdata (mem_rd)
  );

  always_comb begin
    estado_n = estado;
    cnt_n    = cnt;
    wr_n     = wr_ptr;
    rd_n     = rd_ptr;
    led_n    = led_q;
    res_n    = res_q;
    est_n    = est_q;
    we       = 1'b0;
    unique case (estado)
      INICIAL, FIM: begin
        if (iniciar) begin
          estado_n = PULSO_JOGAR;
          cnt_n    = '0;
          wr_n     = '0;
          rd_n     = '0;
          res_n    = RES_NADA;
          est_n    = 1'b0;
        end
      end
      PULSO_JOGAR: begin
        if (cnt == CW'(JOGAR_CICLOS - 1)) begin
          estado_n = ESPERA_LED;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ESPERA_LED: begin
        if (one_hot4(jogo.leds)) begin
          led_n    = jogo.leds;
          estado_n = GRAVA;
          cnt_n    = '0;
        end else if (jogo.leds == 4'b0 && wr_ptr != '0) begin
          if (cnt == CW'(IDLE_TIMEOUT - 1)) begin
            estado_n = REPRODUZ_PRESS;
            rd_n     = '0;
            cnt_n    = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      GRAVA: begin
        estado_n = ESPERA_APAGAR;
        // A full RAM drops the pulse and flags it instead
        if (wr_ptr == PW'(DEPTH)) begin
          est_n = 1'b1;
        end else begin
          we   = 1'b1;
          wr_n = wr_ptr + PW'(1);
        end
      end
      ESPERA_APAGAR: begin
        if (jogo.leds == 4'b0) begin
          estado_n = ESPERA_LED;
          cnt_n    = '0;
        end
      end
      REPRODUZ_PRESS: begin
        if (cnt == CW'(HOLD - 1)) begin
          estado_n = REPRODUZ_SOLTA;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      REPRODUZ_SOLTA: begin
        if (cnt == CW'(GAP - 1)) begin
          cnt_n = '0;
          if (rd_ptr + PW'(1) == wr_ptr) begin
            wr_n     = '0;
            estado_n = ESPERA_LED;
          end else begin
            rd_n     = rd_ptr + PW'(1);
            estado_n = REPRODUZ_PRESS;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: estado_n = INICIAL;
    endcase
    if (jogo.pronto && estado != INICIAL && estado != FIM) begin
      estado_n = FIM;
      we       = 1'b0;
      if (jogo.perdeu || jogo.ganhou)
        res_n = {jogo.perdeu, jogo.ganhou};
      else
        res_n = RES_SEM_FLAG;
    end
  end

  // Outputs are decoded from the next state so they move with it
  always_comb begin
    press_val = mem_rd;
`ifdef JOGADOR_ERRO_EN
    if (wr_n == PW'(erro_rodada) + PW'(1) &&
        rd_n + PW'(1) == wr_n)
      press_val = rotl4(mem_rd);
`endif
    jogar_n  = (estado_n == PULSO_JOGAR);
    botoes_n = (estado_n == REPRODUZ_PRESS) ? press_val : 4'b0;
    ocup_n   = (estado_n != INICIAL) && (estado_n != FIM);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= INICIAL;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      led_q    <= '0;
      res_q    <= RES_NADA;
      est_q    <= 1'b0;
      jogar_q  <= 1'b0;
      botoes_q <= 4'b0;
      ocup_q   <= 1'b0;
    end else begin
      estado   <= estado_n;
      cnt      <= cnt_n;
      wr_ptr   <= wr_n;
      rd_ptr   <= rd_n;
      led_q    <= led_n;
      res_q    <= res_n;
      est_q    <= est_n;
      jogar_q  <= jogar_n;
      botoes_q <= botoes_n;
      ocup_q   <= ocup_n;
    end
  end

  assign jogo.jogar  = jogar_q;
  assign jogo.botoes = botoes_q;
  assign ocupado     = ocup_q;
  assign resultado   = res_q;
  assign estouro     = est_q;
  assign db_estado   = estado;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: a memory-game model shows
// random sequences and judges the replayed presses.
module tb_jogador_automatico;
  import jogador_automatico_pkg::*;

  localparam int HOLD  = 5;
  localparam int GAP   = 5;
  localparam int IDLE  = 20;
  localparam int JC    = 5;
  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       ocupado;
  logic       estouro;
  logic [1:0] resultado;
  logic [3:0] db_estado;
`ifdef JOGADOR_ERRO_EN
  logic [3:0] erro_rodada = 4'd15;
`endif

  int checks   = 0;
  int failures = 0;

  logic [3:0] rv[$];
  int         rl[$];
  logic [3:0] showq[$];
  logic [3:0] seq[$];
  bit         errou;

  jogador_automatico_if jif ();

  jogador_automatico #(
    .HOLD(HOLD), .GAP(GAP), .IDLE_TIMEOUT(IDLE),
    .JOGAR_CICLOS(JC), .DEPTH(DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
`ifdef JOGADOR_ERRO_EN
    .erro_rodada (erro_rodada),
`endif
    .jogo      (jif),
    .ocupado   (ocupado),
    .resultado (resultado),
    .estouro   (estouro),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] replay_val(logic [3:0] v,
                                            int i, int n);
`ifdef JOGADOR_ERRO_EN
    if (n == int'(erro_rodada) + 1 && i == n - 1)
      return {v[2:0], v[3]};
`endif
    return v;
  endfunction

  task automatic show(input logic [3:0] v);
    jif.leds = v;
    repeat (3) @(negedge clock);
    jif.leds = 4'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic collect(input int n);
    logic [3:0] cur;
    int len;
    rv.delete();
    rl.delete();
    @(negedge clock);
    cur = jif.botoes;
    len = 1;
    for (int c = 1; c < IDLE + 10 * n + 20; c++) begin
      @(negedge clock);
      if (jif.botoes === cur) len++;
      else begin
        rv.push_back(cur);
        rl.push_back(len);
        cur = jif.botoes;
        len = 1;
      end
    end
    rv.push_back(cur);
    rl.push_back(len);
  endtask

  task automatic check_replay(input string tag);
    int np = 0;
    int n  = showq.size();
    for (int k = 0; k < rv.size(); k++) begin
      if (rv[k] != 4'b0) begin
        if (np < n) begin
          chk($sformatf("%s val%0d", tag, np), rv[k],
              replay_val(showq[np], np, n));
          if (rv[k] !== showq[np]) errou = 1'b1;
        end
        chk($sformatf("%s hold%0d", tag, np), rl[k], HOLD);
        np++;
      end
    end
    for (int k = 1; k + 1 < rv.size(); k++)
      if (rv[k] == 4'b0 && rv[k-1] != 4'b0 && rv[k+1] != 4'b0)
        chk($sformatf("%s gap%0d", tag, k), rl[k], GAP);
    chk({tag, " count"}, np, n);
  endtask

  task automatic start_game(input string tag);
    int nj = 0;
    errou = 1'b0;
    iniciar = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (c == 0) begin
        iniciar = 1'b0;
        chk({tag, " ocupado"}, ocupado, 1);
        chk({tag, " res_clr"}, resultado, 2'b00);
        chk({tag, " est_clr"}, estouro, 0);
      end
      if (jif.jogar) nj++;
    end
    chk({tag, " jogar_len"}, nj, JC);
    chk({tag, " botoes"}, jif.botoes, 4'b0);
    chk({tag, " estado"}, db_estado, 4'd2);
  endtask

  task automatic end_game(input string tag);
    jif.pronto = 1'b1;
    jif.ganhou = !errou;
    jif.perdeu = errou;
    @(negedge clock);
    jif.pronto = 1'b0;
    jif.ganhou = 1'b0;
    jif.perdeu = 1'b0;
    chk({tag, " resultado"}, resultado, {errou, !errou});
    chk({tag, " fim"}, db_estado, 4'd8);
    chk({tag, " botoes"}, jif.botoes, 4'b0);
    chk({tag, " ocupado"}, ocupado, 0);
  endtask

  task automatic wait_press(input int limit);
    int w = 0;
    while (jif.botoes == 4'b0 && w < limit) begin
      @(negedge clock);
      w++;
    end
  endtask

  initial begin
    jif.leds   = 4'b0;
    jif.pronto = 1'b0;
    jif.ganhou = 1'b0;
    jif.perdeu = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    chk("rst botoes", jif.botoes, 4'b0);
    chk("rst jogar", jif.jogar, 0);
    chk("rst ocupado", ocupado, 0);
    chk("rst resultado", resultado, 2'b00);
    chk("rst estouro", estouro, 0);
    chk("rst estado", db_estado, 4'd0);

    // Game 1: full 16-round game with random one-hot leds
    start_game("g1");
    seq.delete();
    for (int i = 0; i < DEPTH; i++)
      seq.push_back(4'b0001 << $urandom_range(0, 3));
    for (int r = 1; r <= DEPTH; r++) begin
      showq.delete();
      for (int i = 0; i < r; i++) begin
        show(seq[i]);
        showq.push_back(seq[i]);
      end
      collect(r);
      check_replay($sformatf("g1r%0d", r));
    end
    chk("g1 estouro", estouro, 0);
    chk("g1 ocupado", ocupado, 1);
    end_game("g1");

    // Game 2: directed order, then ignored 0011, then loss mid-press
    start_game("g2");
    showq.delete();
    for (int i = 0; i < 4; i++) begin
      show(4'b0001 << i);
      showq.push_back(4'b0001 << i);
    end
    collect(4);
    check_replay("g2e1");
    show(4'b0011);
    show(4'b0100);
    wait_press(80);
    chk("g2 first_press", jif.botoes, 4'b0100);
    errou = 1'b1;
    end_game("g2");

    // Game 3: 17 pulses overflow the 16-entry memory
    start_game("g3");
    showq.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      logic [3:0] v;
      v = 4'b0001 << $urandom_range(0, 3);
      show(v);
      if (i < DEPTH) showq.push_back(v);
    end
    chk("g3 estouro", estouro, 1);
    collect(DEPTH);
    check_replay("g3");
    chk("g3 estouro_sticky", estouro, 1);
    end_game("g3");
    chk("g3 estouro_fim", estouro, 1);

    // Game 4: reset during a press aborts at once
    start_game("g4");
    show(4'b1000);
    show(4'b0010);
    wait_press(80);
    chk("g4 pressing", jif.botoes, 4'b1000);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("g4 rst botoes", jif.botoes, 4'b0);
    chk("g4 rst estado", db_estado, 4'd0);
    chk("g4 rst ocupado", ocupado, 0);
    chk("g4 rst jogar", jif.jogar, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
